carregador_programa: RTL and testbench
======================================

Name: carregador_programa

Overview:
- Program loader directly upstream of the multicycle RISC-V datapath.
- Accepts a stream of 32-bit instruction words over a valid/ready interface and writes them, in order, into instruction memory from address 0.
- Appends the all-zero terminator word that the datapath's ID state treats as end-of-program.
- Raises `core_start` only when the image is complete; the datapath holds in IF until then.

Parameters:
- ADDR_WIDTH, 5, instruction-memory word-address width; DEPTH = 2**ADDR_WIDTH = 32 words.
- DATA_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse; begins a new load (honoured only in OCIOSO, PRONTO or ERRO).
- in_valid  input  1  source has a word on in_data.
- in_data  input  DATA_WIDTH  instruction word.
- in_last  input  1  qualifies the final program word of the stream.
- in_ready  output  1  loader can accept a word this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  DATA_WIDTH  word to write.
- core_start  output  1  level; high while a valid image is resident.
- load_error  output  1  level; high in ERRO.
- word_count  output  ADDR_WIDTH+1  program words accepted, terminator excluded.

Behaviour:
- Reset (rst_n low, asynchronous): state=OCIOSO, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_start=0, load_error=0, word_count=0.
- States: OCIOSO, CARGA, TERMINA, PRONTO, ERRO.
- OCIOSO:
  - in_ready=0.
  - load_start moves to CARGA and clears the address pointer and word_count.
- CARGA:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready at a rising edge.
  - Write is registered: the cycle after acceptance, imem_we=1, imem_addr=pointer, imem_wdata=in_data. The pointer and word_count increment at the acceptance edge.
  - One word per cycle, no bubbles required.
  - in_valid low: no write, stay in CARGA.
  - Beat with in_last=1: go to TERMINA.
  - Beat with in_last=0 accepted at address DEPTH-2: go to ERRO, because there is no room left for the terminator.
- TERMINA:
  - in_ready=0.
  - Single cycle with imem_we=1, imem_addr=pointer (word after the last program word), imem_wdata=0.
  - Then go to PRONTO.
- PRONTO:
  - core_start=1, in_ready=0, imem_we=0.
  - Stays until load_start or reset.
  - load_start clears core_start in the same edge and moves to CARGA, which restarts the core's image.
- ERRO:
  - load_error=1, core_start=0, in_ready=0, imem_we=0.
  - Left only by load_start (to CARGA) or reset.
- in_last on the first beat: 1-word program at address 0, terminator at address 1.
- load_start while in CARGA or TERMINA is ignored; the load is never restarted mid-stream.
- in_data equal to 0 is written as-is. The core will stop at it, and the loader does not check for it.
- Reset asserted mid-load aborts immediately with no further writes. Memory contents are not cleared.
- imem_we is never high in the same cycle as core_start.
- word_count saturates naturally at DEPTH-1 (the maximum legal program length).

Decomposition:
- Shared package (loader_pkg): state encoding constants OCIOSO=3'd0, CARGA=3'd1, TERMINA=3'd2, PRONTO=3'd3, ERRO=3'd4; DEPTH derived constant; TERMINATOR=32'h0.
- No sub-module: the FSM plus pointer register fits in one module (~150 lines).

Test Plan:
- Reset, then load_start, then 3 back-to-back words 0x00A00093, 0x00108133, 0x00002183 (last on the third):
  - Writes at addresses 0, 1, 2 one cycle after each acceptance.
  - Terminator 0x0 written at address 3.
  - core_start rises the cycle after the terminator write; word_count=3.
- Same 3 words with in_valid low for 2 cycles between words 1 and 2:
  - No writes during the gaps.
  - Identical final memory image; word_count=3.
- Stream 31 words (last on word 31):
  - Writes at addresses 0..30, terminator at address 31.
  - core_start=1, load_error=0.
- Stream 31 words, none flagged last:
  - ERRO after the beat at address 30; load_error=1, core_start=0, in_ready=0.
  - No terminator written.
  - Then load_start returns to CARGA with word_count=0.
- rst_n pulsed low after 2 of 5 words:
  - All outputs return to reset values asynchronously.
  - No write for words 3..5; state=OCIOSO.
- load_start asserted in PRONTO after a 1-word load:
  - core_start drops at that edge and in_ready=1 next cycle.
  - New image starts at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// memory geometry and the end-of-program terminator word.
package loader_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

  localparam logic [31:0] TERMINATOR = 32'h0;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARGA   = 3'd1,
    TERMINA = 3'd2,
    PRONTO  = 3'd3,
    ERRO    = 3'd4
  } state_t;

endpackage

// File: rtl/carregador_programa.sv
// Program loader: streams instruction words into instruction memory from
// address 0, appends the all-zero terminator and then releases the core.
module carregador_programa
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_start,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  // Last address a non-final word may occupy; the word after it is reserved
  // for the terminator.
  localparam logic [ADDR_WIDTH-1:0] LAST_PROG_ADDR = ADDR_WIDTH'(MEM_DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE      = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;
  logic                  restart;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      OCIOSO: begin
        if (load_start) next_state = CARGA;
      end
      CARGA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)                  next_state = TERMINA;
          else if (ptr == LAST_PROG_ADDR) next_state = ERRO;
        end
      end
      TERMINA: next_state = PRONTO;
      PRONTO, ERRO: begin
        if (load_start) next_state = CARGA;
      end
      default: next_state = OCIOSO;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign restart = load_start && (state == OCIOSO || state == PRONTO || state == ERRO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OCIOSO;
      ptr        <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values (ptr is read and incremented in the same edge).
      state   <= next_state;
      imem_we <= 1'b0;
      if (restart) begin
        ptr        <= '0;
        word_count <= '0;
      end
      if (accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= ptr;
        imem_wdata <= in_data;
        ptr        <= ptr + ADDR_ONE;
        word_count <= word_count + COUNT_ONE;
      end
      if (state == TERMINA) begin
        imem_we    <= 1'b1;
        imem_addr  <= ptr;
        imem_wdata <= DATA_WIDTH'(TERMINATOR);
      end
    end
  end

  // The terminator write is still draining during the first PRONTO cycle;
  // holding core_start off until it lands keeps the core from fetching a
  // half-written image.
  assign core_start = (state == PRONTO) && !imem_we;
  assign load_error = (state == ERRO);

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: expected memory writes are
// queued as beats are driven and matched against the write port.
module tb_carregador_programa;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_start;
  logic          load_error;
  logic [AW:0]   word_count;

  carregador_programa #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_start (core_start),
    .load_error (load_error),
    .word_count (word_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  logic [DW-1:0] img[32];
  logic [DW-1:0] ref_img[4];
  logic [AW-1:0] exp_addr;
  int            exp_count;
  int            n_cmp;
  int            n_err;
  logic          prev_we;
  logic          prev_cs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("we_with_core_start", 64'(imem_we & core_start), 64'd0);
      if (core_start && !prev_cs) check("cs_after_term", 64'(prev_we), 64'd1);
      if (imem_we) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(imem_we), 64'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 64'(imem_addr), 64'(e.addr));
          check("wr_data", 64'(imem_wdata), 64'(e.data));
        end
        img[imem_addr] = imem_wdata;
      end
      prev_we = imem_we;
      prev_cs = core_start;
    end else begin
      prev_we = 1'b0;
      prev_cs = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    exp_addr   = '0;
    exp_count  = 0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    check("in_ready_carga", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    sb.push_back('{exp_addr, d});
    exp_addr++;
    exp_count++;
    if (last) sb.push_back('{exp_addr, 32'h0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_core_start(input string tag);
    for (int i = 0; i < 10 && !core_start; i++) tick(1);
    check(tag, 64'(core_start), 64'd1);
  endtask

  task automatic end_of_load(input string tag);
    wait_core_start({tag, "_core_start"});
    check({tag, "_count"}, 64'(word_count), 64'(exp_count));
    check({tag, "_error"}, 64'(load_error), 64'd0);
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    prev_we = 1'b0; prev_cs = 1'b0;
    load_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    exp_addr = '0; exp_count = 0;
    for (int i = 0; i < 32; i++) img[i] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_error", 64'(load_error), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // 3-word back-to-back load.
    pulse_start();
    beat(32'h00A0_0093, 1'b0);
    beat(32'h0010_8133, 1'b0);
    beat(32'h0000_2183, 1'b1);
    end_of_load("t1");
    for (int i = 0; i < 4; i++) ref_img[i] = img[i];
    check("t1_img3", 64'(img[3]), 64'd0);

    // Same program with a 2-cycle gap; load_start mid-stream must be ignored.
    for (int i = 0; i < 32; i++) img[i] = 32'hDEAD_BEEF;
    do_reset();
    pulse_start();
    beat(32'h00A0_0093, 1'b0);
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    tick(1);
    beat(32'h0010_8133, 1'b0);
    beat(32'h0000_2183, 1'b1);
    end_of_load("t2");
    for (int i = 0; i < 4; i++) check("t2_image", 64'(img[i]), 64'(ref_img[i]));

    // Maximum-length program: 31 words, terminator at address 31.
    do_reset();
    pulse_start();
    for (int i = 0; i < 31; i++) beat(32'h1000_0000 + 32'(i * 7 + 1), i == 30);
    end_of_load("t3");
    check("t3_term", 64'(img[31]), 64'd0);

    // 31 words without in_last: overflow into ERRO, no terminator.
    do_reset();
    img[31] = 32'h5555_AAAA;
    pulse_start();
    for (int i = 0; i < 31; i++) beat(32'h2000_0000 + 32'(i), 1'b0);
    check("t4_error", 64'(load_error), 64'd1);
    check("t4_core_start", 64'(core_start), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    tick(4);
    check("t4_drained", 64'(sb.size()), 64'd0);
    check("t4_no_term", 64'(img[31]), 64'h5555_AAAA);
    check("t4_error_held", 64'(load_error), 64'd1);
    pulse_start();
    check("t4_restart_ready", 64'(in_ready), 64'd1);
    check("t4_restart_count", 64'(word_count), 64'd0);
    check("t4_restart_error", 64'(load_error), 64'd0);

    // Asynchronous reset after 2 of 5 words.
    do_reset();
    pulse_start();
    beat(32'h3000_0001, 1'b0);
    beat(32'h3000_0002, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_we", 64'(imem_we), 64'd0);
    check("t5_addr", 64'(imem_addr), 64'd0);
    check("t5_wdata", 64'(imem_wdata), 64'd0);
    check("t5_count", 64'(word_count), 64'd0);
    check("t5_core_start", 64'(core_start), 64'd0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h3000_0000 + 32'(i);
      in_last  = (i == 5);
      check("t5_idle_ready", 64'(in_ready), 64'd0);
      tick(1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick(2);
    check("t5_drained", 64'(sb.size()), 64'd0);
    check("t5_idle_count", 64'(word_count), 64'd0);

    // Reload from PRONTO after a 1-word program.
    pulse_start();
    beat(32'h0050_0013, 1'b1);
    end_of_load("t6a");
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    exp_addr   = '0;
    exp_count  = 0;
    check("t6_cs_drop", 64'(core_start), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd1);
    check("t6_count", 64'(word_count), 64'd0);
    beat(32'h0070_0113, 1'b0);
    beat(32'h0000_0000, 1'b1);
    end_of_load("t6b");

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
